// File: rtl/dice_display_ctrl_if.sv
// ----------------------------------------------------------------------------
// dice_display_ctrl_if
//   Bundles the roll button, dice generator link and die-face display outputs
//   of dice_display_ctrl.
//
//   Signals
//     roll_btn    1  level roll request (high = held), synchronous to clk
//     dice_in     3  current value from the dice generator, legal 1..6
//     gen_enable  1  enable to the dice generator
//     pips        7  die-face LEDs: bit0 C, 1 TL, 2 TR, 3 ML, 4 MR, 5 BL, 6 BR
//     face        3  settled result, 0 = no result
//     busy        1  roll in progress (rolling or settling)
//     done        1  one-cycle pulse when a result is captured
//     roll_count  8  completed rolls, saturating at 255
//     err         1  sticky flag: an illegal dice_in value was sampled
//
//   Modports
//     master  the side that presses the button and supplies dice values
//     slave   the controller itself
// ----------------------------------------------------------------------------
interface dice_display_ctrl_if;
   logic       roll_btn;
   logic [2:0] dice_in;
   logic       gen_enable;
   logic [6:0] pips;
   logic [2:0] face;
   logic       busy;
   logic       done;
   logic [7:0] roll_count;
   logic       err;

   modport master (
      output roll_btn, dice_in,
      input  gen_enable, pips, face, busy, done, roll_count, err
   );

   modport slave (
      input  roll_btn, dice_in,
      output gen_enable, pips, face, busy, done, roll_count, err
   );
endinterface

// File: rtl/dice_display_ctrl.sv
// ----------------------------------------------------------------------------
// dice_display_ctrl
//   Controls an electronic die: while the button is held the external dice
//   generator tumbles and the display shows a slowed-down animation of its
//   values; after release the generator keeps tumbling for SETTLE_CYCLES
//   cycles, then the current value is captured as the result and shown
//   until the next roll starts.
//
//   Parameters
//     SETTLE_CYCLES  cycles of tumbling after button release (1..255)
//     ANIM_DIV       cycles between animation refreshes while rolling (1..255)
//
//   Ports
//     clk  rising-edge clock, sole clock domain
//     rst  synchronous active-high reset
//     bus  dice_display_ctrl_if.slave (button, dice value, display outputs)
//
//   All outputs are registered.
// ----------------------------------------------------------------------------
module dice_display_ctrl #(
   parameter int SETTLE_CYCLES = 8,
   parameter int ANIM_DIV      = 4
) (
   input logic                clk,
   input logic                rst,
   dice_display_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ROLLING,
      SETTLE,
      SHOW
   } state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] ANIM_LAST   = 8'(ANIM_DIV - 1);

   state_t     state_q, state_d;
   logic       btn_prev_q;
   logic [7:0] settle_cnt_q;
   logic [7:0] anim_cnt_q;

   logic       gen_enable_q;
   logic [6:0] pips_q;
   logic [2:0] face_q;
   logic       busy_q;
   logic       done_q;
   logic [7:0] roll_count_q;
   logic       err_q;

   logic       enter_roll;
   logic       start_settle;
   logic       capture;
   logic       refresh;
   logic       active_d;
   logic       dice_legal;

   function automatic logic [6:0] decode(input logic [2:0] value);
      case (value)
         3'd1:    decode = 7'h01;
         3'd2:    decode = 7'h42;
         3'd3:    decode = 7'h43;
         3'd4:    decode = 7'h66;
         3'd5:    decode = 7'h67;
         3'd6:    decode = 7'h7E;
         default: decode = 7'h00;
      endcase
   endfunction

   assign dice_legal = (bus.dice_in != 3'd0) && (bus.dice_in != 3'd7);

   // Next-state and per-cycle event decode.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so that no
      // path through the case leaves it unassigned and infers a latch.
      state_d      = state_q;
      enter_roll   = 1'b0;
      start_settle = 1'b0;
      capture      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.roll_btn) begin
               state_d    = ROLLING;
               enter_roll = 1'b1;
            end
         end
         ROLLING: begin
            if (!bus.roll_btn) begin
               state_d      = SETTLE;
               start_settle = 1'b1;
            end
         end
         SETTLE: begin
            // The button is deliberately ignored while settling.
            if (settle_cnt_q == 8'd0) begin
               state_d = SHOW;
               capture = 1'b1;
            end
         end
         SHOW: begin
            // Only a fresh press starts a new roll; a button still held from
            // the previous roll must be released first.
            if (bus.roll_btn && !btn_prev_q) begin
               state_d    = ROLLING;
               enter_roll = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The animation counter keeps running across ROLLING -> SETTLE, so the
   // refresh cadence is uniform over the whole tumbling period.
   assign refresh  = ((state_q == ROLLING) || (state_q == SETTLE)) &&
                     (anim_cnt_q == ANIM_LAST);
   assign active_d = (state_d == ROLLING) || (state_d == SETTLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so that every
         // register samples values from before the edge, independent of
         // statement order.
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_prev_q   <= 1'b0;
         settle_cnt_q <= 8'd0;
         anim_cnt_q   <= 8'd0;
         gen_enable_q <= 1'b0;
         pips_q       <= 7'h00;
         face_q       <= 3'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         roll_count_q <= 8'd0;
         err_q        <= 1'b0;
      end else begin
         btn_prev_q <= bus.roll_btn;

         // gen_enable and busy are computed from the next state so that the
         // registered outputs line up exactly with the state register.
         gen_enable_q <= active_d;
         busy_q       <= active_d;
         done_q       <= capture;

         if (start_settle) begin
            settle_cnt_q <= SETTLE_LOAD;
         end else if ((state_q == SETTLE) && (settle_cnt_q != 8'd0)) begin
            settle_cnt_q <= settle_cnt_q - 8'd1;
         end

         if (enter_roll) begin
            anim_cnt_q <= 8'd0;
         end else if ((state_q == ROLLING) || (state_q == SETTLE)) begin
            anim_cnt_q <= (anim_cnt_q == ANIM_LAST) ? 8'd0 : anim_cnt_q + 8'd1;
         end

         if (enter_roll) begin
            face_q <= 3'd0;
         end else if (capture) begin
            face_q <= dice_legal ? bus.dice_in : 3'd0;
         end

         // Capture and refresh both show the decoded value; an illegal value
         // decodes to a blank display.
         if (capture || refresh) begin
            pips_q <= decode(bus.dice_in);
         end

         if (capture && (roll_count_q != 8'hFF)) begin
            roll_count_q <= roll_count_q + 8'd1;
         end

         if ((capture || refresh) && !dice_legal) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.gen_enable = gen_enable_q;
   assign bus.pips       = pips_q;
   assign bus.face       = face_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.roll_count = roll_count_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_dice_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dice_display_ctrl
//   Self-checking bench for dice_display_ctrl with default parameters.
//   A roll is described by its button hold length, an optional re-press held
//   through settling and display, a tail of idle cycles, and the dice value
//   offered at every edge. Expected outputs follow from the timing rules of a
//   roll: busy for hold+settle cycles, a display refresh every ANIM_DIV-th
//   cycle of that window, and the capture at the edge that ends it.
// ----------------------------------------------------------------------------
module tb_dice_display_ctrl;

   localparam int S = 8;   // settle cycles
   localparam int A = 4;   // animation divider

   logic clk = 1'b0;
   logic rst;

   dice_display_ctrl_if bus ();

   dice_display_ctrl #(
      .SETTLE_CYCLES (S),
      .ANIM_DIV      (A)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Dice value offered at each edge of a roll, filled by each test.
   logic [2:0] dseq [0:63];

   // Reference state carried from roll to roll.
   logic [6:0] m_pips;
   logic [2:0] m_face;
   int         m_rc;
   bit         m_err;

   int obs_gen;
   int obs_done;

   // Pip layout of a die face: the centre is lit for odd values, the main
   // diagonal from 2 up, the anti-diagonal from 4 up, the middle row for 6.
   function automatic logic [6:0] face_pips(input int n);
      logic [6:0] p;
      p = 7'h00;
      if (n >= 1 && n <= 6) begin
         if (n % 2 == 1) p[0] = 1'b1;
         if (n >= 2) begin p[1] = 1'b1; p[6] = 1'b1; end
         if (n >= 4) begin p[2] = 1'b1; p[5] = 1'b1; end
         if (n == 6) begin p[3] = 1'b1; p[4] = 1'b1; end
      end
      return p;
   endfunction

   function automatic bit is_legal(input int n);
      return (n >= 1) && (n <= 6);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_pips = 7'h00;
      m_face = 3'd0;
      m_rc   = 0;
      m_err  = 1'b0;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.roll_btn = 1'b0;
      step();
      step();
      rst = 1'b0;
      model_clear();
   endtask

   // Drives one complete roll and compares every output after every edge.
   // Edge 0 is the press; the button drops at edge h; the capture is at edge
   // h+S. With hold set the button is raised again during settling and kept
   // high through the tail.
   task automatic run_roll(input int h, input bit hold, input int tail);
      bit e_busy, e_done;
      int d;
      obs_gen  = 0;
      obs_done = 0;
      for (int i = 0; i <= h + S + tail; i++) begin
         bus.roll_btn = (i < h) ? 1'b1 : ((hold && i > h) ? 1'b1 : 1'b0);
         bus.dice_in  = dseq[i];
         step();
         d = int'(dseq[i]);
         if (i == 0) m_face = 3'd0;
         if (i == h + S) begin
            m_face = is_legal(d) ? 3'(d) : 3'd0;
            m_pips = face_pips(d);
            m_rc   = (m_rc < 255) ? m_rc + 1 : 255;
            if (!is_legal(d)) m_err = 1'b1;
         end else if (i < h + S && i >= A && i % A == 0) begin
            m_pips = face_pips(d);
            if (!is_legal(d)) m_err = 1'b1;
         end
         e_busy = (i < h + S);
         e_done = (i == h + S);
         if (bus.gen_enable) obs_gen++;
         if (bus.done) obs_done++;
         checks++;
         if ({bus.busy, bus.gen_enable, bus.done, bus.face, bus.pips, bus.roll_count, bus.err} !==
             {e_busy, e_busy, e_done, m_face, m_pips, 8'(m_rc), m_err}) begin
            errors++;
            $display("FAIL roll cyc=%0d h=%0d got busy=%b gen=%b done=%b face=%0d pips=%h cnt=%0d err=%b exp busy=%b gen=%b done=%b face=%0d pips=%h cnt=%0d err=%b",
                     i, h, bus.busy, bus.gen_enable, bus.done, bus.face, bus.pips, bus.roll_count, bus.err,
                     e_busy, e_busy, e_done, m_face, m_pips, m_rc, m_err);
         end
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.roll_btn = 1'b1;
      bus.dice_in  = 3'd6;
      step();
      step();
      checks++;
      if ({bus.busy, bus.gen_enable, bus.done, bus.face, bus.pips, bus.roll_count, bus.err} !== 22'd0) begin
         errors++;
         $display("FAIL reset_values got busy=%b gen=%b done=%b face=%0d pips=%h cnt=%0d err=%b exp all zero",
                  bus.busy, bus.gen_enable, bus.done, bus.face, bus.pips, bus.roll_count, bus.err);
      end
      rst          = 1'b0;
      bus.roll_btn = 1'b0;
      model_clear();
      step();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b exp 0", bus.busy);
      end
   endtask

   task automatic test_basic_roll();
      for (int i = 0; i < 64; i++) dseq[i] = 3'd4;
      run_roll(10, 1'b0, 3);
      checks++;
      if (obs_gen !== 18) begin
         errors++;
         $display("FAIL basic_gen_cycles got %0d exp 18", obs_gen);
      end
      checks++;
      if (obs_done !== 1) begin
         errors++;
         $display("FAIL basic_done_pulses got %0d exp 1", obs_done);
      end
      checks++;
      if ({bus.face, bus.pips, bus.roll_count} !== {3'd4, 7'h66, 8'd1}) begin
         errors++;
         $display("FAIL basic_result got face=%0d pips=%h cnt=%0d exp face=4 pips=66 cnt=1",
                  bus.face, bus.pips, bus.roll_count);
      end
   endtask

   task automatic test_animation();
      for (int i = 0; i < 64; i++) dseq[i] = 3'((i % 6) + 1);
      run_roll(12, 1'b0, 2);
   endtask

   task automatic test_hold_through();
      for (int i = 0; i < 64; i++) dseq[i] = 3'($urandom_range(1, 6));
      run_roll(5, 1'b1, 10);
      bus.roll_btn = 1'b0;
      step();
      checks++;
      if ({bus.busy, bus.face} !== {1'b0, m_face}) begin
         errors++;
         $display("FAIL hold_release got busy=%b face=%0d exp busy=0 face=%0d", bus.busy, bus.face, m_face);
      end
      for (int i = 0; i < 64; i++) dseq[i] = 3'($urandom_range(1, 6));
      run_roll(4, 1'b0, 2);
   endtask

   task automatic test_illegal_capture();
      for (int i = 0; i < 64; i++) dseq[i] = 3'($urandom_range(1, 6));
      dseq[7 + S] = 3'd7;
      run_roll(7, 1'b0, 2);
      checks++;
      if ({bus.err, bus.face, bus.pips} !== {1'b1, 3'd0, 7'h00}) begin
         errors++;
         $display("FAIL illegal_capture got err=%b face=%0d pips=%h exp err=1 face=0 pips=00",
                  bus.err, bus.face, bus.pips);
      end
      for (int i = 0; i < 64; i++) dseq[i] = 3'($urandom_range(1, 6));
      run_roll(3, 1'b0, 2);
   endtask

   task automatic test_illegal_refresh();
      for (int i = 0; i < 64; i++) dseq[i] = 3'd3;
      dseq[1] = 3'd7;   // not a sampling point
      dseq[A] = 3'd0;   // first refresh point
      run_roll(10, 1'b0, 2);
   endtask

   task automatic test_reset_mid_settle();
      int h;
      h = 6;
      for (int i = 0; i < 64; i++) dseq[i] = 3'd5;
      // Counter is S-1-k after edge h+k, so it reads 3 after edge h+4.
      for (int i = 0; i <= h + 4; i++) begin
         bus.roll_btn = (i < h) ? 1'b1 : 1'b0;
         bus.dice_in  = dseq[i];
         step();
      end
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_settle_busy got %b exp 1", bus.busy);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({bus.busy, bus.gen_enable, bus.done, bus.face, bus.pips, bus.roll_count, bus.err} !== 22'd0) begin
         errors++;
         $display("FAIL mid_settle_reset got busy=%b gen=%b done=%b face=%0d pips=%h cnt=%0d err=%b exp all zero",
                  bus.busy, bus.gen_enable, bus.done, bus.face, bus.pips, bus.roll_count, bus.err);
      end
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < S + 2; i++) begin
         step();
         checks++;
         if ({bus.busy, bus.done, bus.roll_count} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL mid_settle_after cyc=%0d got busy=%b done=%b cnt=%0d exp 0 0 0",
                     i, bus.busy, bus.done, bus.roll_count);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 64; i++) dseq[i] = 3'($urandom_range(1, 6));
         run_roll(int'($urandom_range(1, 5)), 1'b0, 0);
      end
   endtask

   task automatic test_saturation();
      for (int r = 0; r < 260; r++) begin
         for (int i = 0; i < 64; i++) dseq[i] = 3'($urandom_range(1, 6));
         run_roll(1, 1'b0, 0);
      end
      checks++;
      if (bus.roll_count !== 8'd255) begin
         errors++;
         $display("FAIL saturation got cnt=%0d exp 255", bus.roll_count);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 15) == 0)
               dseq[i] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
            else
               dseq[i] = 3'($urandom_range(1, 6));
         end
         run_roll(int'($urandom_range(1, 16)), 1'b0, int'($urandom_range(0, 5)));
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.roll_btn = 1'b0;
      bus.dice_in  = 3'd1;
      model_clear();
      test_reset();
      test_basic_roll();
      test_animation();
      test_hold_through();
      test_illegal_capture();
      do_reset();
      test_illegal_refresh();
      test_reset_mid_settle();
      test_back_to_back();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
